// File: rtl/imm_extend_if.sv
// imm_extend_if: handshake/data bundle for the pipelined immediate extender.
//   master : ID-stage driver (imm_in, mode, in_valid, stall, flush out;
//            extended result in)
//   slave  : the extender itself
// Optional: IMMEXT_ZERO_FLAG_EN adds imm_zero (slave -> master).
interface imm_extend_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic [IN_W-1:0]  imm_in;
    logic [1:0]       mode;
    logic             in_valid;
    logic             stall;
    logic             flush;
    logic [OUT_W-1:0] imm_out;
    logic             out_valid;
    logic [1:0]       mode_out;
`ifdef IMMEXT_ZERO_FLAG_EN
    logic             imm_zero;

    modport master (output imm_in, mode, in_valid, stall, flush,
                    input  imm_out, out_valid, mode_out, imm_zero);
    modport slave  (input  imm_in, mode, in_valid, stall, flush,
                    output imm_out, out_valid, mode_out, imm_zero);
`else
    modport master (output imm_in, mode, in_valid, stall, flush,
                    input  imm_out, out_valid, mode_out);
    modport slave  (input  imm_in, mode, in_valid, stall, flush,
                    output imm_out, out_valid, mode_out);
`endif
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: parameterised, pipelined immediate extender for the ID stage.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset (clears data, mode, valid)
//   bus      : imm_extend_if.slave
//              imm_in/mode/in_valid  - raw immediate and extension mode
//                mode 00 sign, 01 zero, 10 upper (LUI), 11 branch (sext << 2)
//              stall/flush           - hold / kill every stage (flush wins)
//              imm_out/out_valid/mode_out - result from the last stage
// Parameters: IN_W (2..OUT_W-2), OUT_W, STAGES (1 or 2).
// Optional: define IMMEXT_ZERO_FLAG_EN to add bus.imm_zero, a registered
//           "extended value is all-zero" flag that follows the same
//           reset/stall/flush rules as the data.

// One register stage: valid bit plus an opaque payload.
module imm_ext_stage #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         stall,
    input  logic         flush,
    input  logic         d_vld,
    input  logic [W-1:0] d_pay,
    output logic         q_vld,
    output logic [W-1:0] q_pay
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_vld <= 1'b0;
            q_pay <= '0;
        end else if (flush) begin
            q_vld <= 1'b0;
            q_pay <= '0;
        end else if (!stall) begin
            q_vld <= d_vld;
            q_pay <= d_pay;
        end
    end
endmodule

module imm_extend_pipe #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int STAGES = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    imm_extend_if.slave  bus
);
    localparam int EXT_W = OUT_W - IN_W;

    generate
        if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
            $error("imm_extend_pipe: STAGES must be 1 or 2");
        end
        if (IN_W < 2 || IN_W > OUT_W - 2) begin : g_bad_width
            $error("imm_extend_pipe: IN_W must be in 2..OUT_W-2");
        end
    endgenerate

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [1:0]       mode;
`ifdef IMMEXT_ZERO_FLAG_EN
        logic             zero;
`endif
    } pay_t;

    localparam int PAY_W = $bits(pay_t);

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;
    pay_t             pay_in;

    // Extension is purely combinational on the stage-0 inputs.
    always_comb begin
        sext = {{EXT_W{bus.imm_in[IN_W-1]}}, bus.imm_in};
        ext  = sext;
        case (bus.mode)
            2'b00:   ext = sext;
            2'b01:   ext = {{EXT_W{1'b0}}, bus.imm_in};
            2'b10:   ext = {bus.imm_in, {EXT_W{1'b0}}};
            default: ext = {sext[OUT_W-3:0], 2'b00};  // top two bits fall off
        endcase
    end

    always_comb begin
        pay_in      = '0;
        pay_in.data = ext;
        pay_in.mode = bus.mode;
`ifdef IMMEXT_ZERO_FLAG_EN
        // Carried from stage 1 so it obeys the same flush/reset clearing
        // as the data, rather than being recomputed from a cleared 0.
        pay_in.zero = (ext == '0);
`endif
    end

    logic [STAGES:0]     vld_pipe;
    pay_t [STAGES:0]     pay_pipe;

    assign vld_pipe[0] = bus.in_valid;
    assign pay_pipe[0] = pay_in;

    // Stage 1 captures the extended value even when in_valid=0; only its
    // valid bit tracks in_valid. Stage 2 (if present) copies stage 1.
    for (genvar s = 1; s <= STAGES; s++) begin : g_stage
        imm_ext_stage #(.W(PAY_W)) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .stall   (bus.stall),
            .flush   (bus.flush),
            .d_vld   (vld_pipe[s-1]),
            .d_pay   (pay_pipe[s-1]),
            .q_vld   (vld_pipe[s]),
            .q_pay   (pay_pipe[s])
        );
    end

    assign bus.imm_out   = pay_pipe[STAGES].data;
    assign bus.mode_out  = pay_pipe[STAGES].mode;
    assign bus.out_valid = vld_pipe[STAGES];
`ifdef IMMEXT_ZERO_FLAG_EN
    assign bus.imm_zero  = pay_pipe[STAGES].zero;
`endif
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: drives a STAGES=1 and a STAGES=2 extender with the same
// stimulus and compares both against a queue-based reference model.
module tb_imm_extend_pipe;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    imm_extend_if #(.IN_W(16), .OUT_W(32)) b1 ();
    imm_extend_if #(.IN_W(16), .OUT_W(32)) b2 ();

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(1)) u_s1 (
        .clk(clk), .reset_n(reset_n), .bus(b1.slave));
    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(2)) u_s2 (
        .clk(clk), .reset_n(reset_n), .bus(b2.slave));

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: extension computed with plain integer arithmetic.
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] md);
        longint u, s, v;
        u = longint'(imm);
        s = (u >= 32768) ? u - 65536 : u;
        case (md)
            2'd0: v = s;
            2'd1: v = u;
            2'd2: v = u * 65536;
            default: v = s * 4;
        endcase
        return v[31:0];
    endfunction

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [1:0]  m;
        logic        z;
    } ent_t;

    ent_t q1[$];
    ent_t q2[$];

    task automatic mdl_clear();
        ent_t e;
        e = '{v: 1'b0, d: 32'h0, m: 2'b0, z: 1'b0};
        q1.delete();
        q2.delete();
        q1.push_back(e);
        q2.push_back(e);
        q2.push_back(e);
    endtask

    task automatic drive(input logic [15:0] imm, input logic [1:0] md,
                         input logic iv, input logic st, input logic fl);
        b1.imm_in = imm; b1.mode = md; b1.in_valid = iv; b1.stall = st; b1.flush = fl;
        b2.imm_in = imm; b2.mode = md; b2.in_valid = iv; b2.stall = st; b2.flush = fl;
    endtask

    task automatic cmp_all();
        chk("s1_valid", 64'(b1.out_valid), 64'(q1[$].v));
        chk("s1_data",  64'(b1.imm_out),   64'(q1[$].d));
        chk("s1_mode",  64'(b1.mode_out),  64'(q1[$].m));
        chk("s2_valid", 64'(b2.out_valid), 64'(q2[$].v));
        chk("s2_data",  64'(b2.imm_out),   64'(q2[$].d));
        chk("s2_mode",  64'(b2.mode_out),  64'(q2[$].m));
`ifdef IMMEXT_ZERO_FLAG_EN
        chk("s1_zero",  64'(b1.imm_zero),  64'(q1[$].z));
        chk("s2_zero",  64'(b2.imm_zero),  64'(q2[$].z));
`endif
    endtask

    // Called at a negedge: apply inputs, advance model, clock, compare.
    task automatic step(input logic [15:0] imm, input logic [1:0] md,
                        input logic iv, input logic st, input logic fl);
        ent_t e;
        drive(imm, md, iv, st, fl);
        if (fl) begin
            mdl_clear();
        end else if (!st) begin
            e.v = iv;
            e.d = ref_ext(imm, md);
            e.m = md;
            e.z = (e.d == 32'h0);
            q1.push_front(e); void'(q1.pop_back());
            q2.push_front(e); void'(q2.pop_back());
        end
        @(posedge clk);
        @(negedge clk);
        cmp_all();
    endtask

    initial begin
        mdl_clear();
        drive(16'h0, 2'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        cmp_all();                              // reset state
        reset_n = 1'b1;

        // Idle after reset release.
        repeat (3) begin
            step(16'h0, 2'b0, 1'b0, 1'b0, 1'b0);
            chk("idle_valid", 64'(b1.out_valid), 64'h0);
            chk("idle_data",  64'(b1.imm_out),   64'h0);
        end

        // One transaction per cycle through the single-stage pipe.
        step(16'h8001, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("sext",   64'(b1.imm_out), 64'hFFFF8001);
        chk("sext_v", 64'(b1.out_valid), 64'h1);
        step(16'h8001, 2'b01, 1'b1, 1'b0, 1'b0);
        chk("zext",   64'(b1.imm_out), 64'h00008001);
        chk("s2_lat", 64'(b2.imm_out), 64'hFFFF8001);
        step(16'h1234, 2'b10, 1'b1, 1'b0, 1'b0);
        chk("upper",  64'(b1.imm_out), 64'h12340000);
        step(16'hFFFE, 2'b11, 1'b1, 1'b0, 1'b0);
        chk("branch", 64'(b1.imm_out), 64'hFFFFFFF8);

        // Two-cycle latency on the two-stage pipe.
        step(16'h0, 2'b0, 1'b0, 1'b0, 1'b0);
        step(16'h0, 2'b0, 1'b0, 1'b0, 1'b0);
        step(16'h7FFF, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("lat2_c1_v", 64'(b2.out_valid), 64'h0);
        step(16'h0, 2'b0, 1'b0, 1'b0, 1'b0);
        chk("lat2_c2",   64'(b2.imm_out), 64'h00007FFF);
        chk("lat2_c2_v", 64'(b2.out_valid), 64'h1);

        // Three stall cycles with an entry in stage 1 of the two-stage pipe.
        step(16'h0123, 2'b01, 1'b1, 1'b0, 1'b0);
        repeat (3) begin
            step(16'hBEEF, 2'b00, 1'b1, 1'b1, 1'b0);
            chk("stall_hold_v", 64'(b2.out_valid), 64'h0);
        end
        step(16'h0, 2'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_deliver",   64'(b2.imm_out), 64'h00000123);
        chk("stall_deliver_v", 64'(b2.out_valid), 64'h1);
        step(16'h0, 2'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_nodup_v",   64'(b2.out_valid), 64'h0);

        // Stall and flush together: flush wins.
        step(16'h5555, 2'b00, 1'b1, 1'b0, 1'b0);
        step(16'hAAAA, 2'b00, 1'b1, 1'b1, 1'b1);
        chk("sf_s1_v", 64'(b1.out_valid), 64'h0);
        chk("sf_s1_d", 64'(b1.imm_out),   64'h0);
        chk("sf_s2_v", 64'(b2.out_valid), 64'h0);
        chk("sf_s2_d", 64'(b2.imm_out),   64'h0);
        step(16'h0010, 2'b01, 1'b1, 1'b0, 1'b0);
        chk("post_flush",   64'(b1.imm_out), 64'h00000010);
        chk("post_flush_v", 64'(b1.out_valid), 64'h1);

`ifdef IMMEXT_ZERO_FLAG_EN
        step(16'h0000, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("zflag_set", 64'(b1.imm_zero), 64'h1);
        step(16'h4000, 2'b11, 1'b1, 1'b0, 1'b0);
        chk("zflag_clr", 64'(b1.imm_zero), 64'h0);
        chk("br_4000",   64'(b1.imm_out),  64'h00010000);
`endif

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(16'($urandom), 2'($urandom),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 9) == 0));
        end

        // Asynchronous reset between edges with a live output.
        step(16'h0042, 2'b00, 1'b1, 1'b0, 1'b0);
        step(16'h0043, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_v", 64'(b1.out_valid), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_s1_v", 64'(b1.out_valid), 64'h0);
        chk("arst_s1_d", 64'(b1.imm_out),   64'h0);
        chk("arst_s2_v", 64'(b2.out_valid), 64'h0);
        chk("arst_s2_d", 64'(b2.imm_out),   64'h0);
        mdl_clear();
        drive(16'h0, 2'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        step(16'h8000, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("rst_recover", 64'(b1.imm_out), 64'hFFFF8000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
